scicad1: RTL and testbench

SCICAD1 -- requirements
Module: scicad1

---
 rtl/scicad1_pkg.sv | 27 ++
 rtl/scicad1_if.sv | 8 +
 rtl/scicad1_uart_tx.sv | 54 +++++
 rtl/scicad1.sv | 73 +++++++
 tb/tb_scicad1.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/scicad1_pkg.sv
// Shared constants for the "Hola!..." UART announcer: baud divisors,
// the message ROM contents and the controller state encoding.
package scicad1_pkg;

    localparam int B9600   = 1250;
    localparam int B19200  = 625;
    localparam int B38400  = 312;
    localparam int B57600  = 208;
    localparam int B115200 = 104;
    localparam int BAUD_DEFAULT = B115200;

    localparam int MSG_LEN = 8;
    // First character occupies the most significant byte.
    localparam logic [8*MSG_LEN-1:0] MSG = 64'h48_6F_6C_61_21_2E_2E_2E;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TXCAR = 2'd1,
        NEXT  = 2'd2,
        END   = 2'd3
    } state_t;

    function automatic logic [7:0] msg_char(input logic [2:0] idx);
        return MSG[8*(MSG_LEN-1-int'(idx)) +: 8];
    endfunction

endpackage

// File: rtl/scicad1_if.sv
// Serial-side bundle of scicad1: the transmit request in, the UART line out.
interface scicad1_if;
    logic dtr;
    logic tx;

    modport master (output dtr, input tx);
    modport slave  (input dtr, output tx);
endinterface

// File: rtl/scicad1_uart_tx.sv
// 8N1 UART transmitter with its own baud counter; LSB first, idle high.
module uart_tx #(
    parameter int BAUD = 104
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam logic [15:0] CNT_LAST = 16'(BAUD - 1);

    logic        busy;
    logic [15:0] cnt;
    logic [3:0]  bitn;
    logic [7:0]  shreg;
    logic        baud_tick;

    assign ready     = ~busy;
    assign baud_tick = (cnt == CNT_LAST);

    // bitn counts the bit currently on the line: 0 = start, 1..8 = data, 9 = stop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy  <= 1'b0;
            cnt   <= '0;
            bitn  <= '0;
            shreg <= '0;
            tx    <= 1'b1;
        end else if (!busy) begin
            if (start) begin
                busy  <= 1'b1;
                cnt   <= '0;
                bitn  <= '0;
                shreg <= data;
                tx    <= 1'b0;
            end
        end else if (baud_tick) begin
            cnt <= '0;
            if (bitn == 4'd9) begin
                busy <= 1'b0;
            end else begin
                tx    <= (bitn == 4'd8) ? 1'b1 : shreg[0];
                shreg <= shreg >> 1;
                bitn  <= bitn + 4'd1;
            end
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/scicad1.sv
// Sends the fixed string "Hola!..." over a UART line while dtr is held high;
// a started string always runs to completion.
module scicad1
    import scicad1_pkg::*;
#(
    parameter int BAUD = BAUD_DEFAULT
) (
    input  logic            clk,
    input  logic            rstn,
    scicad1_if.slave        bus,
    output state_t          dbg_state,
    output logic [2:0]      dbg_index
);

    state_t     state, next_state;
    logic       dtr_r;
    logic [2:0] index;
    logic       start;
    logic       ready;
    logic [7:0] data;

    // Handshake to uart_tx: a character is accepted on a clock edge where
    // start and ready are both 1; ready stays 0 until that frame's stop bit ends.

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) dtr_r <= 1'b0;
        else       dtr_r <= bus.dtr;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (dtr_r) next_state = TXCAR;
            TXCAR: if (ready) next_state = NEXT;
            NEXT:  if (ready) next_state = (index == 3'd7) ? END : TXCAR;
            END:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        start = (state == TXCAR);
        data  = msg_char(index);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            index <= '0;
        end else if (state == IDLE) begin
            index <= '0;
        end else if (state == NEXT && ready && index != 3'd7) begin
            index <= index + 3'd1;
        end
    end

    uart_tx #(.BAUD(BAUD)) u_tx (
        .clk   (clk),
        .rstn  (rstn),
        .start (start),
        .data  (data),
        .tx    (bus.tx),
        .ready (ready)
    );

    assign dbg_state = state;
    assign dbg_index = index;

endmodule

// File: tb/tb_scicad1.sv
// Bench for scicad1: a monitor decodes UART frames off tx and checks them
// against bytes queued when each request is issued.
module tb_scicad1;
    import scicad1_pkg::*;

    localparam int B = 104;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    scicad1_if bus();
    state_t     dbg_state;
    logic [2:0] dbg_index;

    scicad1 #(.BAUD(B)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus.slave),
        .dbg_state (dbg_state),
        .dbg_index (dbg_index)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    logic [7:0] hola[8] = '{8'h48, 8'h6F, 8'h6C, 8'h61, 8'h21, 8'h2E, 8'h2E, 8'h2E};
    int checks = 0;
    int failures = 0;
    int frames = 0;
    bit gap_chk = 1'b0;
    bit have_prev = 1'b0;
    int prev_fall = 0;

    task automatic check_eq(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_le(input string name, input int act, input int lim);
        checks++;
        if (act > lim) begin
            failures++;
            $display("FAIL %s actual=%0d required<=%0d (t=%0t)", name, act, lim, $time);
        end
    endtask

    // ---------------- monitor ----------------
    int         fall;
    bit         abort;
    logic [9:0] bits_a, bits_b;

    initial begin
        forever begin
            @(negedge clk);
            if (rstn && bus.tx === 1'b0) begin
                fall  = cyc;
                abort = 1'b0;
                bits_a = '0;
                bits_b = '0;
                // j indexes negedges since the start-bit edge; sample the first
                // and last cycle of every bit to pin each bit to exactly B cycles.
                for (int j = 0; j < 10*B; j++) begin
                    if (j > 0) @(negedge clk);
                    if (!rstn) begin
                        abort = 1'b1;
                        break;
                    end
                    if (j % B == 0)     bits_a[j/B] = bus.tx;
                    if (j % B == B - 1) bits_b[j/B] = bus.tx;
                end
                if (!abort) begin
                    frames++;
                    check_eq("bit_width", int'(bits_a), int'(bits_b));
                    check_eq("framing", int'({bits_a[9], bits_a[0]}), 2);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_frame actual=%0h required=none", bits_a[8:1]);
                    end else begin
                        check_eq("byte", int'(bits_a[8:1]), int'(exp_q.pop_front()));
                    end
                    if (gap_chk && have_prev) check_le("gap", fall - prev_fall - 10*B, 4);
                    prev_fall = fall;
                    have_prev = 1'b1;
                end else begin
                    have_prev = 1'b0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_string();
        for (int i = 0; i < 8; i++) exp_q.push_back(hola[i]);
    endtask

    task automatic idle_check(input string name, input int n);
        int lows;
        lows = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.tx !== 1'b1) lows++;
        end
        check_eq(name, lows, 0);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq(name, exp_q.size(), 0);
    endtask

    task automatic wait_frames(input string name, input int f0, input int n, input int budget);
        int k;
        k = 0;
        while (frames - f0 < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_le(name, n, frames - f0);
    endtask

    // ---------------- stimulus ----------------
    int f0;
    int lat;

    initial begin
        bus.dtr = 1'b0;
        rstn    = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_tx", int'(bus.tx), 1);
        check_eq("rst_state", int'(dbg_state), int'(IDLE));
        check_eq("rst_index", int'(dbg_index), 0);
        rstn = 1'b1;

        // Quiet line with no request.
        idle_check("idle_no_dtr", 1000);

        // 208-cycle pulse: exactly one string.
        f0 = frames;
        have_prev = 1'b0;
        gap_chk = 1'b1;
        push_string();
        bus.dtr = 1'b1;
        repeat (208) @(negedge clk);
        bus.dtr = 1'b0;
        wait_drain("drain_pulse208", 9000);
        gap_chk = 1'b0;
        check_eq("frames_pulse208", frames - f0, 8);
        idle_check("idle_after_pulse208", 500);

        // 104-cycle pulse: start latency and a second identical string.
        f0 = frames;
        push_string();
        bus.dtr = 1'b1;
        lat = 0;
        while (lat < 12 && bus.tx !== 1'b0) begin
            @(negedge clk);
            lat++;
        end
        check_le("start_latency", lat, 5);
        repeat (104 - lat) @(negedge clk);
        bus.dtr = 1'b0;
        wait_drain("drain_pulse104", 9000);
        check_eq("frames_pulse104", frames - f0, 8);
        idle_check("idle_after_pulse104", 300);

        // dtr held: three back-to-back strings with tight gaps.
        f0 = frames;
        have_prev = 1'b0;
        gap_chk = 1'b1;
        push_string();
        push_string();
        push_string();
        bus.dtr = 1'b1;
        wait_frames("held_reach_str3", f0, 17, 20000);
        bus.dtr = 1'b0;
        wait_drain("drain_held", 9000);
        gap_chk = 1'b0;
        check_eq("frames_held", frames - f0, 24);
        idle_check("idle_after_held", 300);

        // dtr dropped during character 3: string still completes.
        f0 = frames;
        push_string();
        bus.dtr = 1'b1;
        wait_frames("drop_reach_c3", f0, 3, 4000);
        repeat (300) @(negedge clk);
        bus.dtr = 1'b0;
        wait_drain("drain_drop", 9000);
        check_eq("frames_drop", frames - f0, 8);
        idle_check("idle_after_drop", 300);

        // Reset during character 2 (while a 0 data bit is on the line).
        f0 = frames;
        push_string();
        bus.dtr = 1'b1;
        wait_frames("rst_reach_c2", f0, 2, 3000);
        repeat (250) @(negedge clk);
        #2 rstn = 1'b0;
        #1 check_eq("rst_async_tx", int'(bus.tx), 1);
        exp_q.delete();
        repeat (5) @(negedge clk);
        check_eq("rst_mid_state", int'(dbg_state), int'(IDLE));
        check_eq("rst_mid_index", int'(dbg_index), 0);
        f0 = frames;
        push_string();
        rstn = 1'b1;
        wait_frames("restart_first", f0, 1, 2000);
        bus.dtr = 1'b0;
        wait_drain("drain_restart", 9000);
        check_eq("frames_restart", frames - f0, 8);
        idle_check("idle_after_restart", 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
